// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with valid/ready handshakes on both sides
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;
  half_adder h0 (.x(x), .y(y), .s(s0), .c(c0));
  half_adder h1 (.x(s0), .y(ci), .s(s), .c(c1));
  assign co = c0 | c1;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_next;
  logic [CW-1:0] cnt;
  logic c_q, s, c_next, last;
  full_adder fa (.x(a_q[0]), .y(b_q[0]), .ci(c_q), .s(s), .co(c_next));
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = in_valid ? RUN : IDLE;
      RUN:     state_next = last ? DONE : RUN;
      DONE:    state_next = out_ready ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end
  // New sum bit enters at the MSB so the LSB-first result lands aligned after WIDTH shifts.
  always_comb begin
    sum_next = sum_q >> 1;
    sum_next[WIDTH-1] = s;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
      cnt   <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q   <= a;
      b_q   <= b;
      sum_q <= '0;
      c_q   <= c_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      sum_q <= sum_next;
      c_q   <= c_next;
      cnt   <= cnt + 1'b1;
    end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign sum       = sum_q;
  assign c_out     = c_q;
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It adds them LSB-first, one bit per clock, using a single full-adder cell built from two half adders and an OR, with the carry held in a flop between cycles. It returns the WIDTH-bit sum and carry-out through a second valid/ready handshake. It is the area-minimal alternative to the parallel adders in the library and sits between an operand producer and any consumer that tolerates WIDTH-cycle latency.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range ≥ 1.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; asynchronous, active-high; clears all state.
- IN_VALID  input  1  producer presents A, B, C_IN.
- IN_READY  output  1  block can accept an operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- C_IN  input  1  carry-in to bit 0.
- OUT_VALID  output  1  SUM and C_OUT hold a completed result.
- OUT_READY  input  1  consumer takes the result.
- SUM  output  WIDTH  result bits [WIDTH-1:0] of A+B+C_IN.
- C_OUT  output  1  bit WIDTH of A+B+C_IN.
- BUSY  output  1  high in RUN or DONE.

## Operation
- **FSM states:** IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE:**
  - IN_READY=1.
  - On IN_VALID=1 at an edge, capture A and B into shift registers and C_IN into the carry flop, clear the bit counter, clear the sum register, and go to RUN.
- **RUN:**
  - Each edge: s = a0^b0^c, c_next = (a0&b0)|(c&(a0^b0)).
  - Shift both operand registers right by one.
  - Shift the sum register right, inserting s at bit WIDTH-1.
  - c <= c_next; counter++.
  - On the edge where counter == WIDTH-1, go to DONE.
  - The counter is clog2(WIDTH+1) bits wide and never wraps.
- **DONE:**
  - OUT_VALID=1. SUM = sum register, C_OUT = carry flop, both stable.
  - On OUT_READY=1 at an edge, go to IDLE.
- **Outputs:**
  - IN_READY, OUT_VALID and BUSY are pure state decodes, glitch-free from flops.
  - SUM and C_OUT are driven directly from registers.
- **Ignored inputs:**
  - IN_VALID, A, B and C_IN are ignored outside IDLE.
  - Input changes after the capture edge do not affect the result.
  - OUT_READY is ignored outside DONE.
- **Arithmetic:** {C_OUT, SUM} == A + B + C_IN exactly, modulo 2^(WIDTH+1). No overflow flag.
- **WIDTH=1:** RUN lasts exactly one edge.
- **Reset mid-operation:** RST asserted in any state aborts immediately, asynchronously. State goes to IDLE and all registers clear; the partial result is discarded and OUT_VALID is never raised for that operation.

## Timing
- **Reset values:** IN_READY=1, OUT_VALID=0, SUM=0, C_OUT=0, BUSY=0. Internal shift registers, counter and carry are 0.
- **Accept edge E0:** IN_VALID & IN_READY are sampled high at E0.
  - Edges E1..EWIDTH process bits 0..WIDTH-1.
  - OUT_VALID rises after EWIDTH, so latency is WIDTH cycles from the accept edge.
  - IN_READY falls and BUSY rises after E0.
- **Result handshake:** a result handshake at edge Ek returns the FSM to IDLE after Ek, and IN_READY=1 in the following cycle.
- **Throughput:** minimum issue interval is WIDTH+2 cycles with OUT_READY held high.
- **Backpressure:** OUT_VALID, SUM and C_OUT are held unchanged indefinitely while OUT_READY=0, and no new operation is accepted.
- **Simultaneous events:**
  - IN_VALID high in the same cycle that DONE completes is not accepted at that edge; it is accepted at the next edge, in IDLE.
  - RST has priority over every handshake.

## Test plan
- **Carry ripple:** WIDTH=8, A=0xFF, B=0x01, C_IN=0 -> SUM=0x00, C_OUT=1; OUT_VALID rises exactly 8 cycles after the accept edge.
- **Carry-in propagation:** A=0xA5, B=0x5A, C_IN=1 -> SUM=0x00, C_OUT=1. A=0x3C, B=0x0F, C_IN=0 -> SUM=0x4B, C_OUT=0.
- **Backpressure:** complete an operation, hold OUT_READY=0 for 5 cycles while IN_VALID=1 with new operands -> SUM and C_OUT stable, IN_READY=0, BUSY=1, no capture. Raise OUT_READY -> IDLE next cycle, then the pending operation is accepted.
- **Reset mid-run:** assert RST after bit 3 of A=0xF0, B=0x0F -> all outputs read reset values immediately; OUT_VALID never asserts. Release RST, issue A=0x01, B=0x01 -> SUM=0x02, C_OUT=0.
- **Back-to-back streaming:** issue 4 random operations with OUT_READY=1 -> accepts spaced exactly 10 cycles apart. Each result equals the reference A+B+C_IN, and input changes after capture have no effect.
- **WIDTH=1 instance:** all 8 combinations of A, B, C_IN -> correct {C_OUT, SUM}; latency 1 cycle, issue interval 3 cycles.
